// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: sequencing FSM for the 8x8 sequential multiplier datapath.
// Each 8x8 product is built from four 4x4 partial products over CALC0..CALC3.
// The FSM drives the operand nibble selects, the left_shifter code and the
// accumulator enables, then pulses done for one cycle.
// Build option: define SEQ_MULT_CTRL_ERR_EN to flag start seen mid-sequence
// (goes to ERR). Without it, start is ignored while busy and err stays 0.
module seq_mult_ctrl (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   output logic       sel_a,
   output logic       sel_b,
   output logic [1:0] shift_cntrl,
   output logic       acc_en,
   output logic       acc_load,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [2:0] state_out
);

   localparam logic [1:0] SHIFT_0 = 2'b00;
   localparam logic [1:0] SHIFT_4 = 2'b01;
   localparam logic [1:0] SHIFT_8 = 2'b10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CALC0 = 3'd1,
      CALC1 = 3'd2,
      CALC2 = 3'd3,
      CALC3 = 3'd4,
      DONE  = 3'd5,
      ERR   = 3'd6
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   abort;

`ifdef SEQ_MULT_CTRL_ERR_EN
   // A new request while the sequence is in flight is a protocol error.
   assign abort = start;
`else
   // Requests while busy are ignored; the sequence always completes.
   assign abort = 1'b0;
`endif

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // updates from the values present before the edge.
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: defaulting state_nxt first guarantees every path assigns it,
      // so no latch is inferred.
      state_nxt = state;
      case (state)
         IDLE:  state_nxt = start ? CALC0 : IDLE;
         CALC0: state_nxt = abort ? ERR : CALC1;
         CALC1: state_nxt = abort ? ERR : CALC2;
         CALC2: state_nxt = abort ? ERR : CALC3;
         CALC3: state_nxt = abort ? ERR : DONE;
         DONE:  state_nxt = start ? CALC0 : IDLE;
         ERR:   state_nxt = start ? ERR : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Moore output decode from the registered state only.
   always_comb begin
      sel_a       = 1'b0;
      sel_b       = 1'b0;
      shift_cntrl = SHIFT_0;
      acc_en      = 1'b0;
      acc_load    = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      case (state)
         CALC0: begin
            // Low x low, loads the accumulator so no clear cycle is needed.
            acc_en   = 1'b1;
            acc_load = 1'b1;
            busy     = 1'b1;
         end
         CALC1: begin
            sel_a       = 1'b1;
            shift_cntrl = SHIFT_4;
            acc_en      = 1'b1;
            busy        = 1'b1;
         end
         CALC2: begin
            sel_b       = 1'b1;
            shift_cntrl = SHIFT_4;
            acc_en      = 1'b1;
            busy        = 1'b1;
         end
         CALC3: begin
            sel_a       = 1'b1;
            sel_b       = 1'b1;
            shift_cntrl = SHIFT_8;
            acc_en      = 1'b1;
            busy        = 1'b1;
         end
         DONE: begin
            done = 1'b1;
         end
`ifdef SEQ_MULT_CTRL_ERR_EN
         ERR: begin
            err = 1'b1;
         end
`endif
         default: begin
         end
      endcase
   end

   assign state_out = state;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl: directed, table-driven bench for seq_mult_ctrl.
// Models the operand mux, 4x4 multiplier, left shifter and accumulator from
// the control outputs and checks per-cycle control words and final products.
module tb_seq_mult_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       sel_a, sel_b, acc_en, acc_load, busy, done, err;
   logic [1:0] shift_cntrl;
   logic [2:0] state_out;

   logic [7:0]  a, b;
   logic [15:0] acc;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] prod;
   } vec_t;

   // Expected control word per state:
   // {sel_a, sel_b, shift_cntrl, acc_en, acc_load, busy, done, err, state_out}
   typedef struct {
      string      name;
      logic [11:0] word;
   } row_t;

   vec_t vecs[5];
   row_t rows[7];

   seq_mult_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .sel_a      (sel_a),
      .sel_b      (sel_b),
      .shift_cntrl(shift_cntrl),
      .acc_en     (acc_en),
      .acc_load   (acc_load),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .state_out  (state_out)
   );

   always #5 clk = ~clk;

   // Behavioural datapath: mux -> 4x4 mult -> left shifter -> accumulator.
   function automatic logic [15:0] shifted_pp(input logic sa, input logic sb,
                                              input logic [1:0] sc,
                                              input logic [7:0] va, input logic [7:0] vb);
      logic [3:0]  na, nb;
      logic [15:0] pp;
      na = sa ? va[7:4] : va[3:0];
      nb = sb ? vb[7:4] : vb[3:0];
      pp = 16'(na * nb);
      case (sc)
         2'b01:   return pp << 4;
         2'b10:   return pp << 8;
         default: return pp;
      endcase
   endfunction

   always @(posedge clk) begin
      if (acc_en) begin
         if (acc_load) acc <= shifted_pp(sel_a, sel_b, shift_cntrl, a, b);
         else          acc <= acc + shifted_pp(sel_a, sel_b, shift_cntrl, a, b);
      end
   end

   task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Compare the full control word against the expected row for a state.
   task automatic check_state(input string tag, input int s);
      logic [11:0] w;
      w = {sel_a, sel_b, shift_cntrl, acc_en, acc_load, busy, done, err, state_out};
      check({tag, "/", rows[s].name}, {4'h0, w}, {4'h0, rows[s].word});
   endtask

   // Start at the current negedge (state IDLE or DONE), step through
   // CALC0..DONE checking each cycle, and check the product in DONE.
   task automatic run_mult(input string tag, input int idx);
      a     = vecs[idx].a;
      b     = vecs[idx].b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int s = 1; s <= 5; s++) begin
         if (s > 1) @(negedge clk);
         check_state(tag, s);
      end
      check({tag, "/prod"}, acc, vecs[idx].prod);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{8'hAB, 8'hCD, 16'h88EF};
      vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
      vecs[2] = '{8'h00, 8'h37, 16'h0000};
      vecs[3] = '{8'h10, 8'h10, 16'h0100};
      vecs[4] = '{8'h0F, 8'hF0, 16'h0E10};

      rows[0] = '{"IDLE",  {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}};
      rows[1] = '{"CALC0", {1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1}};
      rows[2] = '{"CALC1", {1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2}};
      rows[3] = '{"CALC2", {1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3}};
      rows[4] = '{"CALC3", {1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4}};
      rows[5] = '{"DONE",  {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5}};
      rows[6] = '{"ERR",   {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6}};

      reset_n = 1'b0;
      start   = 1'b0;
      a       = 8'h00;
      b       = 8'h00;
      repeat (2) @(negedge clk);
      check_state("reset", 0);
      reset_n = 1'b1;
      @(negedge clk);
      check_state("idle_after_reset", 0);

      // Single multiply with a one-cycle start pulse, then back to IDLE.
      run_mult("single", 0);
      @(negedge clk);
      check_state("single_end", 0);

      // Back-to-back: start re-asserted in DONE goes straight to CALC0.
      for (int i = 1; i <= 3; i++) begin
         run_mult($sformatf("b2b%0d", i), i);
      end
      @(negedge clk);
      check_state("b2b_end", 0);

      // Reset in CALC2 aborts without a done pulse.
      a     = 8'hAB;
      b     = 8'hCD;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_state("abort", 1);
      repeat (2) @(negedge clk);
      check_state("abort", 3);
      reset_n = 1'b0;
      @(negedge clk);
      check_state("abort_reset", 0);
      reset_n = 1'b1;
      @(negedge clk);
      check_state("abort_idle", 0);
      run_mult("after_abort", 4);
      @(negedge clk);
      check_state("after_abort_end", 0);

      // start re-asserted during CALC1.
      a     = 8'hAB;
      b     = 8'hCD;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_state("midstart", 1);
      @(negedge clk);
      check_state("midstart", 2);
      start = 1'b1;
      @(negedge clk);
`ifdef SEQ_MULT_CTRL_ERR_EN
      check_state("midstart", 6);
      @(negedge clk);
      check_state("midstart_hold", 6);
      start = 1'b0;
      @(negedge clk);
      check_state("midstart_exit", 0);
`else
      start = 1'b0;
      check_state("midstart", 3);
      @(negedge clk);
      check_state("midstart", 4);
      @(negedge clk);
      check_state("midstart", 5);
      check("midstart/prod", acc, 16'h88EF);
      @(negedge clk);
      check_state("midstart_end", 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
